// File: rtl/pc_next_if.sv
// Next-PC generator bus: control/datapath inputs from the core and the
// PC-register controls returned by the generator.
interface pc_next_if;
    logic [2:0]  state;
    logic [31:0] pc_curr;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] rs_data;
    logic [31:0] pc_prev;
    logic        pcctl;
    logic        delay_pending;
    logic        active;
    logic        addr_err;

    // Core side: drives FSM state and resolved control, consumes the next PC.
    modport master (
        output state, pc_curr, branch_taken, branch_imm, jump, jump_index,
               jump_reg, rs_data,
        input  pc_prev, pcctl, delay_pending, active, addr_err
    );

    // Generator side.
    modport slave (
        input  state, pc_curr, branch_taken, branch_imm, jump, jump_index,
               jump_reg, rs_data,
        output pc_prev, pcctl, delay_pending, active, addr_err
    );
endinterface

// File: rtl/pc_next.sv
// Next-PC generator for the multi-cycle MIPS core. Branch/jump targets are
// resolved in EXECUTE, held for one fetch to honour the delay slot, then
// handed to the PC register. Detects halt (jump to 0) and misaligned JR.
module pc_next #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    pc_next_if.slave bus
);

    typedef enum logic [2:0] {
        FETCH_INSTR   = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100
    } state_e;

    state_e      cur_state;
    logic [31:0] target_reg;
    logic        pending;
    logic        halted;
    logic        addr_err;

    logic        is_fetch;
    logic        capture;
    logic        misaligned;
    logic [31:0] capture_target;
    logic [31:0] branch_offset;

    assign cur_state     = state_e'(bus.state);
    assign is_fetch      = (cur_state == FETCH_INSTR);
    // Controls are meaningful only while the instruction is in EXECUTE.
    assign capture       = (cur_state == EXECUTE) &&
                           (bus.jump_reg || bus.jump || bus.branch_taken);
    assign misaligned    = bus.jump_reg && (bus.rs_data[1:0] != 2'b00);
    // Word offset, sign-extended and scaled to bytes.
    assign branch_offset = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

    // Select the capture target by fixed priority JR > J > branch.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        capture_target = bus.pc_curr + branch_offset;
        if (bus.jump_reg) begin
            capture_target = bus.rs_data;
        end else if (bus.jump) begin
            capture_target = {bus.pc_curr[31:28], bus.jump_index, 2'b00};
        end
    end

    // Drive the PC register controls and status outputs.
    always_comb begin
        // Reset gates the write-enable combinationally, not just via state.
        bus.pcctl         = is_fetch && !halted && !reset;
        bus.pc_prev       = pending ? target_reg : (bus.pc_curr + 32'd4);
        bus.delay_pending = pending;
        bus.active        = !halted;
        bus.addr_err      = addr_err;
    end

    // Capture targets in EXECUTE, consume them at the delay-slot fetch, and
    // track the sticky halt and address-error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            target_reg <= RESET_VECTOR;
            pending    <= 1'b0;
            halted     <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            // Capture (EXECUTE) and consume (FETCH) are in different states,
            // so they never collide; a later capture simply overwrites.
            if (capture) begin
                pending    <= 1'b1;
                target_reg <= capture_target;
                if (misaligned) begin
                    addr_err <= 1'b1;
                end
            end else if (bus.pcctl && pending) begin
                pending <= 1'b0;
            end
            // The fetch that writes address 0 is the last one to proceed.
            if (bus.pcctl && (bus.pc_prev == 32'h0000_0000)) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_next.sv
// Self-checking bench for pc_next: directed scenarios followed by random
// instruction streams compared against a delay-slot queue model.
module tb_pc_next;

    localparam logic [2:0] S_FETCH = 3'b000;
    localparam logic [2:0] S_DEC   = 3'b001;
    localparam logic [2:0] S_EXEC  = 3'b010;
    localparam logic [2:0] S_MEM   = 3'b011;
    localparam logic [2:0] S_WB    = 3'b100;

    typedef struct packed {
        logic        bt;
        logic [15:0] imm;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] rs;
    } ctrl_t;

    logic clk;
    logic reset;

    pc_next_if bus ();

    pc_next #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a PC register plus a queue of at most one target
    // waiting for the delay-slot fetch.
    logic [31:0] pc_reg;
    logic [31:0] tgt_q[$];
    bit          m_halted;
    bit          m_err;

    // Outputs observed mid-cycle by the most recent cycle() call.
    logic [31:0] obs_prev;
    logic        obs_pcctl;
    logic        obs_delay;
    logic        obs_active;
    logic        obs_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input ctrl_t c, input logic [31:0] pc);
        int offset;
        if (c.jr) return c.rs;
        if (c.j)  return (pc & 32'hF000_0000) | ({6'b0, c.idx} << 2);
        offset = int'($signed(c.imm)) * 4;
        return pc + 32'(offset);
    endfunction

    // One clock cycle: drive at posedge+1, check at mid-cycle, advance model.
    task automatic cycle(input logic [2:0] st, input ctrl_t c);
        logic        exp_pcctl;
        logic [31:0] exp_prev;
        bus.state        = st;
        bus.pc_curr      = pc_reg;
        bus.branch_taken = c.bt;
        bus.branch_imm   = c.imm;
        bus.jump         = c.j;
        bus.jump_index   = c.idx;
        bus.jump_reg     = c.jr;
        bus.rs_data      = c.rs;
        #3;
        exp_pcctl = (st == S_FETCH) && !m_halted;
        exp_prev  = (tgt_q.size() != 0) ? tgt_q[0] : pc_reg + 32'd4;
        check("pcctl",         {31'b0, bus.pcctl},         {31'b0, exp_pcctl});
        check("pc_prev",       bus.pc_prev,                exp_prev);
        check("delay_pending", {31'b0, bus.delay_pending}, {31'b0, tgt_q.size() != 0});
        check("active",        {31'b0, bus.active},        {31'b0, !m_halted});
        check("addr_err",      {31'b0, bus.addr_err},      {31'b0, m_err});
        obs_prev   = bus.pc_prev;
        obs_pcctl  = bus.pcctl;
        obs_delay  = bus.delay_pending;
        obs_active = bus.active;
        obs_err    = bus.addr_err;
        @(posedge clk);
        if (st == S_EXEC && (c.jr || c.j || c.bt)) begin
            tgt_q.delete();
            tgt_q.push_back(model_target(c, pc_reg));
            if (c.jr && c.rs[1:0] != 2'b00) m_err = 1'b1;
        end
        if (exp_pcctl) begin
            if (tgt_q.size() != 0) void'(tgt_q.pop_front());
            if (exp_prev == 32'h0) m_halted = 1'b1;
            pc_reg = exp_prev;
        end
        #1;
    endtask

    // Async reset asserted between edges, held across one edge, released at posedge+1.
    task automatic do_reset(input bit exec_jump, input logic [25:0] idx);
        bus.state        = exec_jump ? S_EXEC : S_FETCH;
        bus.pc_curr      = pc_reg;
        bus.branch_taken = 1'b0;
        bus.branch_imm   = '0;
        bus.jump         = exec_jump;
        bus.jump_index   = idx;
        bus.jump_reg     = 1'b0;
        bus.rs_data      = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_pcctl",    {31'b0, bus.pcctl},         32'h0);
        check("rst_delay",    {31'b0, bus.delay_pending}, 32'h0);
        check("rst_active",   {31'b0, bus.active},        32'h1);
        check("rst_addr_err", {31'b0, bus.addr_err},      32'h0);
        tgt_q.delete();
        m_halted = 1'b0;
        m_err    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_pcctl", {31'b0, bus.pcctl}, 32'h0);
        reset = 1'b0;
    endtask

    function automatic ctrl_t rand_ctrl();
        ctrl_t c;
        int    pick;
        c.bt  = ($urandom % 3) == 0;
        c.j   = ($urandom % 5) == 0;
        c.jr  = ($urandom % 6) == 0;
        c.imm = 16'($urandom);
        c.idx = 26'($urandom);
        pick  = int'($urandom % 8);
        if (pick == 0)      c.rs = 32'h0;
        else if (pick == 1) c.rs = $urandom | 32'h1;
        else                c.rs = $urandom & 32'hFFFF_FFFC;
        return c;
    endfunction

    task automatic rand_instr();
        cycle(S_FETCH, rand_ctrl());
        cycle(S_DEC,   rand_ctrl());
        cycle(S_EXEC,  rand_ctrl());
        if ($urandom % 2 == 0) cycle(S_MEM, rand_ctrl());
        cycle(S_WB,    rand_ctrl());
    endtask

    initial begin
        ctrl_t none;
        ctrl_t c;
        int    halted_run;
        none        = '0;
        reset       = 1'b1;
        pc_reg      = 32'h0;
        m_halted    = 1'b0;
        m_err       = 1'b0;
        bus.state   = S_FETCH;
        bus.pc_curr = '0;
        bus.branch_taken = 1'b0;
        bus.branch_imm   = '0;
        bus.jump         = 1'b0;
        bus.jump_index   = '0;
        bus.jump_reg     = 1'b0;
        bus.rs_data      = '0;
        @(posedge clk);
        #1;
        do_reset(1'b0, '0);

        // Sequential flow.
        pc_reg = 32'hBFC0_0000;
        cycle(S_FETCH, none);
        check("seq_pc_prev", obs_prev, 32'hBFC0_0004);
        check("seq_pcctl_fetch", {31'b0, obs_pcctl}, 32'h1);
        cycle(S_DEC, none);
        check("seq_pcctl_dec", {31'b0, obs_pcctl}, 32'h0);
        cycle(S_EXEC, none);
        cycle(S_WB, none);
        check("seq_delay", {31'b0, obs_delay}, 32'h0);

        // Backward branch.
        pc_reg = 32'hBFC0_0010;
        c = none; c.bt = 1'b1; c.imm = 16'hFFFC;
        cycle(S_EXEC, c);
        cycle(S_WB, none);
        check("bwd_delay_set", {31'b0, obs_delay}, 32'h1);
        cycle(S_FETCH, none);
        check("bwd_pc_prev", obs_prev, 32'hBFC0_0000);
        cycle(S_DEC, none);
        check("bwd_delay_clr", {31'b0, obs_delay}, 32'h0);

        // Jump priority: JR beats J.
        pc_reg = 32'hBFC0_0008;
        c = none; c.j = 1'b1; c.idx = 26'h000_0040; c.jr = 1'b1; c.rs = 32'h0000_1000;
        cycle(S_EXEC, c);
        cycle(S_WB, none);
        cycle(S_FETCH, none);
        check("prio_pc_prev", obs_prev, 32'h0000_1000);
        cycle(S_DEC, none);

        // Misaligned JR.
        c = none; c.jr = 1'b1; c.rs = 32'h0000_0402;
        cycle(S_EXEC, c);
        cycle(S_WB, none);
        check("mis_addr_err", {31'b0, obs_err}, 32'h1);
        cycle(S_FETCH, none);
        check("mis_pc_prev", obs_prev, 32'h0000_0402);
        cycle(S_DEC, none);
        check("mis_sticky", {31'b0, obs_err}, 32'h1);

        // Halt on jump to 0.
        c = none; c.jr = 1'b1; c.rs = 32'h0;
        cycle(S_EXEC, c);
        cycle(S_WB, none);
        cycle(S_FETCH, none);
        check("halt_pc_prev", obs_prev, 32'h0);
        check("halt_pcctl", {31'b0, obs_pcctl}, 32'h1);
        cycle(S_DEC, none);
        check("halt_active", {31'b0, obs_active}, 32'h0);
        cycle(S_EXEC, none);
        cycle(S_WB, none);
        cycle(S_FETCH, none);
        check("halt_no_fetch", {31'b0, obs_pcctl}, 32'h0);

        // Reset while a branch target is pending.
        c = none; c.bt = 1'b1; c.imm = 16'h0010;
        cycle(S_EXEC, c);
        cycle(S_WB, none);
        check("rp_pending", {31'b0, obs_delay}, 32'h1);
        do_reset(1'b0, '0);
        cycle(S_FETCH, none);
        check("rp_fetch_pc", obs_prev, 32'h0000_0004);
        cycle(S_DEC, none);

        // Release of reset during EXECUTE with J: capture on first edge after.
        do_reset(1'b1, 26'h000_0100);
        c = none; c.j = 1'b1; c.idx = 26'h000_0100;
        cycle(S_EXEC, c);
        cycle(S_WB, none);
        cycle(S_FETCH, none);
        check("rel_jump_pc", obs_prev, 32'h0000_0400);
        cycle(S_DEC, none);
        cycle(S_EXEC, none);
        cycle(S_WB, none);

        // Random instruction streams.
        halted_run = 0;
        for (int i = 0; i < 400; i++) begin
            rand_instr();
            if (m_halted) halted_run++;
            if (halted_run >= 2 || ($urandom % 40) == 0) begin
                do_reset(1'b0, '0);
                if ($urandom % 4 == 0) pc_reg = $urandom & 32'hFFFF_FFFC;
                halted_run = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_next.md
# pc_next

Next-PC generator for the multi-cycle MIPS core, directly upstream of the PC register. It supplies the PC register's `pc_prev` data and `pcctl` write-enable. Taken branches, J/JAL and JR/JALR are resolved during EXECUTE and held as a pending target, which is applied one fetch later to honour the MIPS branch delay slot. It also detects program termination (a jump to address 0) and flags misaligned register-jump targets.

## Interface
- `RESET_VECTOR`, 32'h00000000: value of the captured target register after reset.
- `clk` input 1: core clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high. Clears all internal state immediately.
- `state` input 3: control FSM state.
  - Encodings: FETCH_INSTR=000, DECODE=001, EXECUTE=010, MEMORY_ACCESS=011, WRITE_BACK=100.
- `pc_curr` input 32: current PC register value.
- `branch_taken` input 1: conditional branch condition true. Sampled in EXECUTE only.
- `branch_imm` input 16: branch immediate offset, in words.
- `jump` input 1: J/JAL in EXECUTE.
- `jump_index` input 26: J-type instruction index.
- `jump_reg` input 1: JR/JALR in EXECUTE.
- `rs_data` input 32: register rs value, used as the JR/JALR target.
- `pc_prev` output 32: next PC value, driven to the PC register.
- `pcctl` output 1: PC register write-enable.
- `delay_pending` output 1: a captured target is waiting for the delay-slot fetch.
- `active` output 1: high while the CPU has not halted.
- `addr_err` output 1: sticky flag; a misaligned JR/JALR target was captured.

## Operation
- Internal registers:
  - `target_reg[31:0]`: reset value `RESET_VECTOR`.
  - `pending`: reset 0.
  - `halted`: reset 0.
  - `addr_err`: reset 0.
- Combinational outputs:
  - `pcctl` = (state==FETCH_INSTR) & ~halted & ~reset.
  - `pc_prev` = pending ? target_reg : pc_curr + 4.
  - `delay_pending` = pending.
  - `active` = ~halted.
- Capture: on a clock edge with state==EXECUTE and any of `jump_reg`, `jump` or `branch_taken` set.
  - `pending` <= 1.
  - `target_reg` <= target, chosen by fixed priority `jump_reg` > `jump` > `branch_taken`:
    - JR/JALR: `rs_data`.
    - J/JAL: {pc_curr[31:28], jump_index, 2'b00}.
    - Branch: pc_curr + ({{14{branch_imm[15]}}, branch_imm, 2'b00}). Arithmetic is 32-bit modulo 2^32; the wrap is silent.
  - In EXECUTE, `pc_curr` already equals branch address + 4. This is the architecturally correct base.
  - A JR/JALR capture with rs_data[1:0] != 0 sets `addr_err`. It stays set until reset. The target is still captured unmodified.
- Consume: on a clock edge with `pcctl`=1 and `pending`=1, `pending` <= 0. The PC register loads `target_reg` on that same edge.
- Halt: on a clock edge with `pcctl`=1 and `pc_prev`==0, `halted` <= 1. It is sticky until reset.
  - The delay-slot instruction, already fetched, completes normally.
  - No further FETCH asserts `pcctl`.
- All capture/branch inputs are ignored in every state other than EXECUTE.
- Branch in a delay slot: `pending` clears at the delay-slot fetch, before that slot's EXECUTE. A capture there therefore sets a fresh target (last writer wins). Capture and consume never coincide.

## Timing
- Capture latency: a target captured at the end of EXECUTE of instruction A is loaded into PC at the end of the FETCH of instruction A+4, i.e. the next FETCH_INSTR cycle.
- Non-branch flow: PC advances by 4 at the end of each FETCH_INSTR cycle.
- `pcctl` is high for exactly the FETCH_INSTR cycle(s) and is otherwise 0.
- Asynchronous reset mid-operation:
  - `pending`, `halted` and `addr_err` drop to 0 immediately, and `target_reg` goes to `RESET_VECTOR`.
  - `pcctl` is 0 for as long as reset is high.
  - The first FETCH after reset release writes pc_curr+4.
- Reset released while state==EXECUTE with `jump` set: capture occurs on the first rising edge after release.

## Test plan
- Sequential flow: pc_curr=0xBFC00000, state cycles FETCH→DECODE→EXECUTE→WRITE_BACK with no controls -> `pc_prev`=0xBFC00004 and `pcctl`=1 only in FETCH; `delay_pending`=0 throughout.
- Backward branch: EXECUTE with pc_curr=0xBFC00010, branch_taken=1, branch_imm=16'hFFFC -> `delay_pending`=1; at the next FETCH `pc_prev`=0xBFC00000, and after that edge `delay_pending`=0.
- Jump priority: EXECUTE with pc_curr=0xBFC00008, jump=1, jump_index=26'h0000040, jump_reg=1, rs_data=0x00001000 -> next FETCH `pc_prev`=0x00001000 (JR wins over J).
- Halt: jump_reg=1, rs_data=0 in EXECUTE -> next FETCH drives `pc_prev`=0 with `pcctl`=1; after that edge `active`=0, and the following FETCH has `pcctl`=0.
- Misaligned JR: rs_data=0x00000402 -> `addr_err`=1 and stays 1 across later cycles; `pc_prev`=0x00000402 at the next FETCH.
- Reset mid-pending: capture a branch, then assert reset asynchronously between clock edges -> `delay_pending`, `addr_err`=0 at once and `active`=1; the first FETCH after release gives `pc_prev`=pc_curr+4.
